// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RISC-V M-extension multiply/divide unit
//
// Purpose: executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// Operands are reduced to magnitudes at accept. One bit is resolved per
// cycle in CALC. FIX restores the sign and selects the result half.
// Divide by zero and signed overflow skip CALC and go straight to DONE.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   kill       synchronous flush, abandons the current operation
//   in_valid   request valid
//   in_ready   request accepted (IDLE state, low while rst is high)
//   op         funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a, b       rs1 / rs2 operands, sampled only at accept
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     result, stable while out_valid and held in IDLE
//
// Configuration macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies
// complete in a single cycle on a native multiplier. Divides are unchanged.

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_res_q, neg_res_d;   // product / quotient sign
    logic              neg_rem_q, neg_rem_d;   // remainder sign (sign of a)
    logic [XLEN-1:0]   mag_b_q, mag_b_d;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;           // mult {hi, multiplier}; div {rem, quotient}
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand signedness: MULH is signed x signed. MULHSU is signed x unsigned.
    // DIV and REM are signed. The low product half of MUL does not depend on sign.
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_sgn = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_sgn = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One shift-add step: conditionally add the multiplicand, then shift right.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_b_q : '0)};

    // One restoring-division step. The partial remainder is always below the
    // divisor, so bit XLEN of the difference is the borrow.
    logic [XLEN:0] div_shift, div_diff;
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended operands: the low 2*XLEN bits of the product are exact.
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{a_neg}}, a} * {{XLEN{b_neg}}, b};
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    mag_b_d   = b_mag;
                    cnt_d     = '0;
                    if (op[2] && (b == '0)) begin
                        result_d = op[1] ? a : '1;
                        state_d  = S_DONE;
                    end else if (op[2] && !op[0] && (a == MIN_NEG) && (b == '1)) begin
                        result_d = op[1] ? '0 : a;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!op[2]) begin
                        result_d = (op[1:0] == 2'd0) ? fast_prod[XLEN-1:0]
                                                     : fast_prod[2*XLEN-1:XLEN];
                        state_d  = S_DONE;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!op_q[2]) begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end else if (!div_diff[XLEN]) begin
                    acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!op_q[2]) begin
                    result_d = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0]
                                                   : prod_fix[2*XLEN-1:XLEN];
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush leaves the last delivered result intact.
        if (kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit (XLEN=32)

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, kill, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .kill(kill),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built on 64-bit host arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, uy, p;
        logic [63:0] up;
        int qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        uy = {32'b0, y};
        qx = x;
        qy = y;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(qx / qy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(qx % qy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1;
        if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return 34;
    endfunction

    // Called at a falling edge with the unit idle. Returns at a falling edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
        int lat;
        logic [31:0] e;
        in_valid = 1'b1; op = o; a = x; b = y;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_latency(o, x, y)));
        e = sb_q.pop_front();
        check("result", result, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int viol;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Reference vectors with hand-derived constants.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 32'd2);
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd5, 32'd0, 32'd5);
        run_op(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd9, 32'd0, 32'd9);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Random vectors against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 3'(i);
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(15, 1)) : $urandom;
            if (i % 5 == 0) ra = -ra;
            run_op(ro, ra, rb, ref_result(ro, ra, rb));
        end

        // Back-pressure in DONE.
        in_valid = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        sb_q.push_back(32'd14);
        @(negedge clk);
        in_valid = 1'b0;
        viol = 0;
        while (!out_valid && viol < 100) begin @(negedge clk); viol++; end
        ra = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, ra);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_in_ready", 32'(in_ready), 32'd1);

        // Kill at CALC cycle 10, together with out_ready and in_valid.
        in_valid = 1'b1; op = 3'd0; a = 32'd7; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("kill_in_ready", 32'(in_ready), 32'd1);
        check("kill_out_valid", 32'(out_valid), 32'd0);
        check("kill_result_held", result, 32'd14);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) viol++;
        end
        check("kill_no_out_valid", 32'(viol), 32'd0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2);

        // Asynchronous reset in the middle of CALC.
        in_valid = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h1234_5678, 32'h8765_4321, ref_result(3'd1, 32'h1234_5678, 32'h8765_4321));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
